// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch/pipeline sequencing controller.
package fetch_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam int unsigned TIMEOUT_DEF = 16;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned STALL_CNT_W = 16;
   localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_ctrl_wait_timer.sv
// Data-memory wait counter: clear, increment, and expiry at TIMEOUT.
module wait_timer
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/fetch_ctrl.sv
// Pipeline sequencing controller: PC advance/hold/redirect, stalls, bubbles,
// flushes, dmem wait handling with timeout and deferred redirects.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect_i,
   input  logic [ADDR_W-1:0]      redirect_addr_i,
   input  logic                   load_use_i,
   input  logic                   dmem_req_i,
   input  logic                   dmem_valid_i,
   output logic                   pc_en_o,
   output logic                   pc_sel_o,
   output logic [ADDR_W-1:0]      next_addr_o,
   output logic                   stall_all_o,
   output logic                   stall_fe_o,
   output logic                   bubble_o,
   output logic                   flush_o,
   output logic                   mem_err_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   state_e                   state_q, state_d;
   logic                     pend_vld_q, pend_vld_d;
   logic [ADDR_W-1:0]        pend_addr_q, pend_addr_d;
   logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic                     tmr_clr, tmr_inc, tmr_expire;
   logic                     run_rules;
   logic                     redir_any;
   logic [ADDR_W-1:0]        redir_addr;

   wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (tmr_clr),
      .inc_i    (tmr_inc),
      .expire_o (tmr_expire)
   );

   // A live redirect always beats a deferred one.
   assign redir_any  = redirect_i | pend_vld_q;
   assign redir_addr = redirect_i ? redirect_addr_i : pend_addr_q;

   always_comb begin
      state_d     = state_q;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      tmr_clr     = 1'b0;
      tmr_inc     = 1'b0;
      run_rules   = 1'b0;
      pc_en_o     = 1'b0;
      pc_sel_o    = 1'b0;
      next_addr_o = '0;
      stall_all_o = 1'b0;
      stall_fe_o  = 1'b0;
      bubble_o    = 1'b0;
      flush_o     = 1'b0;
      mem_err_o   = 1'b0;

      case (state_q)
         RUN: begin
            if (dmem_req_i && !dmem_valid_i) begin
               stall_all_o = 1'b1;
               tmr_inc     = 1'b1;
               state_d     = MEM_WAIT;
               if (redirect_i) begin
                  pend_vld_d  = 1'b1;
                  pend_addr_d = redirect_addr_i;
               end
            end else begin
               run_rules = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_valid_i || tmr_expire) begin
               mem_err_o = !dmem_valid_i;
               run_rules = 1'b1;
               tmr_clr   = 1'b1;
               state_d   = RUN;
            end else begin
               stall_all_o = 1'b1;
               tmr_inc     = 1'b1;
               if (redirect_i) begin
                  pend_vld_d  = 1'b1;
                  pend_addr_d = redirect_addr_i;
               end
            end
         end
         default: state_d = RUN;
      endcase

      // Redirect outranks load-use: the hazarding instruction gets flushed.
      if (run_rules) begin
         if (redir_any) begin
            pc_en_o     = 1'b1;
            pc_sel_o    = 1'b1;
            next_addr_o = redir_addr;
            flush_o     = 1'b1;
            pend_vld_d  = 1'b0;
         end else if (load_use_i) begin
            stall_fe_o = 1'b1;
            bubble_o   = 1'b1;
         end else begin
            pc_en_o = 1'b1;
         end
      end

      if (!rst) begin
         pc_en_o     = 1'b0;
         pc_sel_o    = 1'b0;
         next_addr_o = '0;
         stall_all_o = 1'b0;
         stall_fe_o  = 1'b0;
         bubble_o    = 1'b0;
         flush_o     = 1'b0;
         mem_err_o   = 1'b0;
      end
   end

   // Saturating stall-cycle counter.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((stall_all_o || stall_fe_o) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Pipeline sequencing controller for the RV32I pipelined core. It decides each cycle whether the program counter advances, holds, or loads a redirect target. It generates stall, bubble and flush controls for the pipeline registers, and handles data-memory wait states and taken branches/jumps. It sits between the EX/MEM-stage hazard sources and the PC register and pipeline registers.

## Interface
- `TIMEOUT`, default 16: maximum dmem wait cycles before the access is aborted.
- `CNT_W`, default 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `redirect_i` in 1: single-cycle pulse from EX for a taken branch or jump. It is valid even while the pipeline is frozen.
- `redirect_addr_i` in 32: redirect target, qualified by `redirect_i`.
- `load_use_i` in 1: load-use hazard flagged by ID.
- `dmem_req_i` in 1: MEM stage holds a valid load/store.
- `dmem_valid_i` in 1: data memory response or completion.
- `pc_en_o` out 1: PC register update enable.
- `pc_sel_o` out 1: 1 = PC loads `next_addr_o`; 0 = PC loads PC+4.
- `next_addr_o` out 32: redirect target presented to the PC.
- `stall_all_o` out 1: freeze PC and every pipeline register.
- `stall_fe_o` out 1: freeze PC and IF/ID.
- `bubble_o` out 1: load NOP into ID/EX.
- `flush_o` out 1: clear IF/ID and ID/EX.
- `mem_err_o` out 1: one-cycle pulse on dmem timeout.
- `stall_cnt_o` out 16: saturating count of stall cycles.

## Operation
- State machine states: RUN, MEM_WAIT.
- Registered state:
  - state
  - `wait_cnt` [CNT_W-1:0]
  - `pend_vld` and `pend_addr` [31:0] (deferred redirect)
  - `stall_cnt`
- The effective redirect is `redirect_i`, otherwise `pend_vld`. `redirect_i` wins if both are present; its address is used and the pending entry is cleared.
- RUN, priority order, all outputs combinational:
  1. `dmem_req_i && !dmem_valid_i`:
     - Drive `stall_all_o`=1, `pc_en_o`=0.
     - Next state MEM_WAIT, `wait_cnt`←1.
     - If `redirect_i` is high, latch it into pending (`pend_vld`←1, `pend_addr`←`redirect_addr_i`).
  2. Effective redirect:
     - Drive `pc_en_o`=1, `pc_sel_o`=1, `next_addr_o`=target, `flush_o`=1.
     - Clear pending.
     - Redirect overrides `load_use_i`, because the hazarding instruction is flushed.
  3. `load_use_i`: drive `stall_fe_o`=1, `bubble_o`=1, `pc_en_o`=0.
  4. Otherwise: `pc_en_o`=1, `pc_sel_o`=0.
- MEM_WAIT:
  - `dmem_valid_i`=0 and `wait_cnt` < TIMEOUT:
    - Drive `stall_all_o`=1, `pc_en_o`=0.
    - `wait_cnt`++.
    - If `redirect_i` is high, latch it into pending; the last redirect wins.
  - `dmem_valid_i`=1:
    - Stall releases this cycle.
    - RUN rules 2–4 apply; rule 1 is skipped.
    - Next state RUN, `wait_cnt`←0.
  - `wait_cnt`==TIMEOUT and `dmem_valid_i`=0:
    - `mem_err_o`=1 for this cycle.
    - Stall releases and RUN rules 2–4 apply.
    - Next state RUN, `wait_cnt`←0.
- `stall_cnt` increments on every cycle where `stall_all_o|stall_fe_o` is high, saturating at 0xFFFF (no wrap).
- `next_addr_o` = `pend_addr` when only pending is valid, `redirect_addr_i` otherwise. It is 0 when no redirect is active.
- Reset (`rst`=0, any time, including mid-MEM_WAIT):
  - State RUN, `wait_cnt`=0, `pend_vld`=0, `pend_addr`=0, `stall_cnt`=0.
  - All outputs are forced to 0, including `pc_en_o`=0.
  - A pending redirect is discarded.

## Timing
- All control outputs are combinational from current state and inputs, valid in the same cycle.
- The PC and pipeline registers act on the next rising edge.
- Redirect latency: `redirect_i` at cycle N leads to PC = target after edge N+1. A deferred redirect applies in the release cycle, so PC = target one edge after `dmem_valid_i`.
- A dmem access that completes in its request cycle (`dmem_valid_i` with `dmem_req_i`) causes zero stall cycles.
- A timeout asserts `mem_err_o` in the TIMEOUT-th wait cycle, after TIMEOUT+1 total stall-related cycles counting the entry cycle.
- `stall_cnt_o` is registered: it reflects stalls up to the previous edge.

## Structure
- Shared package `fetch_ctrl_pkg`:
  - state enum (RUN=1'b0, MEM_WAIT=1'b1)
  - `TIMEOUT` default
  - `NOP` encoding 32'h0000_0013 (used by the bubble consumer)
- Optional single sub-module `wait_timer`: the `wait_cnt` counter with clear, increment and expire output.
- Everything else stays flat in `fetch_ctrl`.

## Test plan
- Reset release, no hazards:
  - `pc_en_o`=1, `pc_sel_o`=0 every cycle.
  - Asserting `rst`=0 mid-stream forces all outputs to 0 immediately.
- `redirect_i`=1 with `redirect_addr_i`=0x0000_0100 in one cycle:
  - Same cycle: `pc_sel_o`=1, `next_addr_o`=0x100, `flush_o`=1.
  - Next cycle: `flush_o`=0.
- `load_use_i`=1 for one cycle:
  - `stall_fe_o`=1, `bubble_o`=1, `pc_en_o`=0 in that cycle.
  - Simultaneous `redirect_i`: redirect wins, `bubble_o`=0.
- `dmem_req_i`=1 with `dmem_valid_i` arriving after 3 cycles:
  - `stall_all_o`=1 for 3 cycles, then releases in the valid cycle.
  - `stall_cnt_o` = 3.
- `redirect_i` (addr 0x200) during a dmem stall:
  - `pend_vld` is set and the PC is held.
  - In the `dmem_valid_i` cycle: `pc_sel_o`=1, `next_addr_o`=0x200, `flush_o`=1.
- dmem never responds with TIMEOUT=16:
  - `mem_err_o` pulses in the 16th MEM_WAIT cycle, the state returns to RUN, and `pc_en_o`=1 in that cycle.
  - Separately, force 70000 stall cycles: `stall_cnt_o` saturates at 0xFFFF.
